// File: rtl/dmux_cdc_rx_pkg.sv
// Shared constants and helpers for the DMUX clock-domain-crossing receiver.
package dmux_cdc_rx_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Rising edge of a level, given its current and one-cycle-delayed value.
    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/dmux_cdc_rx_if.sv
// Data bus with level qualifier from the source domain, plus captured word and strobe.
interface dmux_cdc_rx_if
    import dmux_cdc_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out
    );
endinterface

// File: rtl/dmux_cdc_rx_sync.sv
// Multi-flop single-bit synchroniser; the first flop may go metastable and is given
// the remaining stages to resolve before the value is used.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_r;

    // Shift the asynchronous level through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];
endmodule

// File: rtl/dmux_cdc_rx.sv
// DMUX CDC receiver: only the qualifier is synchronised; its synchronised rising edge
// selects the quasi-static source data bus into the clk_s capture register.
module dmux_cdc_rx
    import dmux_cdc_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic          clk_s,
    input  logic          rst,
    dmux_cdc_rx_if.slave  bus
);
    logic                  valid_sync_s;
    logic                  sync_d_r;
    logic                  sel_s;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_out_r;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_valid_sync (
        .clk (clk_s),
        .rst (rst),
        .d   (bus.valid_in),
        .q   (valid_sync_s)
    );

    // Mux select: one-cycle pulse on the synchronised qualifier rising.
    always_comb begin
        sel_s = rise_edge(valid_sync_s, sync_d_r);
    end

    // Edge-delay flop plus capture register; data_in is only ever read under sel_s.
    always_ff @(posedge clk_s or posedge rst) begin
        if (rst) begin
            sync_d_r    <= 1'b0;
            data_out_r  <= {DATA_WIDTH{1'b0}};
            valid_out_r <= 1'b0;
        end else begin
            sync_d_r <= valid_sync_s;
            if (sel_s) begin
                data_out_r  <= bus.data_in;
                valid_out_r <= 1'b1;
            end else begin
                data_out_r  <= data_out_r;
                valid_out_r <= 1'b0;
            end
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.valid_out = valid_out_r;
endmodule

// File: tb/tb_dmux_cdc_rx.sv
// Directed bench for dmux_cdc_rx: clk_s 20 ns, source clock 10 ns, two-stage sync.
module tb_dmux_cdc_rx;
    logic clk_s   = 1'b0;
    logic clk_src = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int base;

    dmux_cdc_rx_if #(.DATA_WIDTH(8)) bus ();

    dmux_cdc_rx #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_s (clk_s),
        .rst   (rst),
        .bus   (bus)
    );

    always #10 clk_s   = ~clk_s;
    always #5  clk_src = ~clk_src;

    // Count valid_out pulses, sampled away from the active edge.
    always @(negedge clk_s) begin
        if (bus.valid_out === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input int hi, input int gap);
        @(posedge clk_src);
        bus.data_in  = d;
        bus.valid_in = 1'b1;
        repeat (hi) @(posedge clk_src);
        bus.valid_in = 1'b0;
        repeat (gap) @(posedge clk_src);
    endtask

    initial begin
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;

        // Reset: outputs zero throughout.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_s);
            check("rst_data", {24'h0, bus.data_out}, 32'h0);
            check("rst_valid", {31'h0, bus.valid_out}, 32'h0);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk_s);

        // Single transfer with edge-exact latency.
        base = pulse_cnt;
        @(posedge clk_src);
        bus.data_in  = 8'h5A;
        bus.valid_in = 1'b1;
        @(posedge clk_s); #1;
        check("lat_edge_k", {31'h0, bus.valid_out}, 32'h0);
        @(posedge clk_s); #1;
        check("lat_edge_k1", {31'h0, bus.valid_out}, 32'h0);
        @(posedge clk_s); #1;
        check("lat_edge_k2_valid", {31'h0, bus.valid_out}, 32'h1);
        check("lat_edge_k2_data", {24'h0, bus.data_out}, 32'h5A);
        @(posedge clk_s); #1;
        check("pulse_width", {31'h0, bus.valid_out}, 32'h0);
        repeat (4) @(posedge clk_src);
        bus.valid_in = 1'b0;
        repeat (20) @(posedge clk_src);
        check("single_pulses", pulse_cnt - base, 32'd1);
        check("single_data", {24'h0, bus.data_out}, 32'h5A);

        // Back-to-back transfers, data held between pulses.
        base = pulse_cnt;
        send(8'h24, 10, 20);
        check("b2b_first_pulses", pulse_cnt - base, 32'd1);
        check("b2b_first_held", {24'h0, bus.data_out}, 32'h24);
        send(8'h81, 10, 20);
        check("b2b_second_pulses", pulse_cnt - base, 32'd2);
        check("b2b_second_data", {24'h0, bus.data_out}, 32'h81);

        // Long valid: only one capture.
        base = pulse_cnt;
        send(8'hC3, 100, 20);
        check("long_pulses", pulse_cnt - base, 32'd1);
        check("long_data", {24'h0, bus.data_out}, 32'hC3);

        // Data toggling while valid low: nothing captured.
        base = pulse_cnt;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_src);
            bus.data_in = 8'($urandom);
        end
        repeat (10) @(posedge clk_src);
        check("idle_pulses", pulse_cnt - base, 32'd0);
        check("idle_data", {24'h0, bus.data_out}, 32'hC3);

        // Reset one cycle after valid rises; capture restarts from the cleared chain.
        @(posedge clk_src);
        bus.data_in  = 8'h7E;
        bus.valid_in = 1'b1;
        @(posedge clk_s); #1;
        @(negedge clk_s);
        rst = 1'b1;
        #1;
        check("midrst_data_async", {24'h0, bus.data_out}, 32'h0);
        check("midrst_valid_async", {31'h0, bus.valid_out}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_s);
            check("midrst_data", {24'h0, bus.data_out}, 32'h0);
            check("midrst_valid", {31'h0, bus.valid_out}, 32'h0);
        end
        base = pulse_cnt;
        rst = 1'b0;
        @(posedge clk_s); #1;
        check("post_rst_k", {31'h0, bus.valid_out}, 32'h0);
        @(posedge clk_s); #1;
        check("post_rst_k1", {31'h0, bus.valid_out}, 32'h0);
        @(posedge clk_s); #1;
        check("post_rst_k2_valid", {31'h0, bus.valid_out}, 32'h1);
        check("post_rst_k2_data", {24'h0, bus.data_out}, 32'h7E);
        repeat (6) @(posedge clk_src);
        bus.valid_in = 1'b0;
        repeat (20) @(posedge clk_src);
        check("post_rst_pulses", pulse_cnt - base, 32'd1);
        check("post_rst_data", {24'h0, bus.data_out}, 32'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
